// File: rtl/card_dealer.sv
// Finite-shoe card dealer: LFSR-picked ranks with a linear-scan fallback.
// Define DEALER_HOLD_CARD_EN to keep CARD stable between deals.
module card_dealer #(
  parameter int DECKS     = 1,
  parameter int ACE_VALUE = 11,
  parameter int MAX_TRIES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SEED,
  input  logic        DRAW,
  input  logic        SHUFFLE,
  output logic [3:0]  CARD,
  output logic        CARD_VALID,
  output logic        BUSY,
  output logic        EMPTY,
  output logic        ERR,
  output logic [7:0]  CARDS_LEFT
);

  localparam logic [3:0]  RANK_FULL = 4'(4 * DECKS);
  localparam logic [7:0]  SHOE_FULL = 8'(52 * DECKS);
  localparam logic [3:0]  ACE_CARD  = 4'(ACE_VALUE);
  localparam logic [7:0]  LAST_TRY  = 8'(MAX_TRIES - 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] SEED_ZERO = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    SCAN,
    DEAL
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q [13];
  logic [3:0]  cnt_d [13];
  logic [7:0]  left_q, left_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] lfsr_nxt;
  logic [7:0]  tries_q, tries_d;
  logic [3:0]  rank_q, rank_d;
  logic [3:0]  card_q, card_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        pick_ok;

  function automatic logic [3:0] rank_value(
    input logic [3:0] r
  );
    if (r == 4'd0) begin
      return ACE_CARD;
    end else if (r <= 4'd8) begin
      return r + 4'd1;
    end else begin
      return 4'd10;
    end
  endfunction

  assign lfsr_nxt = {1'b0, lfsr_q[15:1]}
                  ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);

  assign pick_ok = (lfsr_nxt[3:0] <= 4'd12)
                && (cnt_q[lfsr_nxt[3:0]] != 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    lfsr_d  = lfsr_q;
    tries_d = tries_q;
    rank_d  = rank_q;
`ifdef DEALER_HOLD_CARD_EN
    card_d  = card_q;
`else
    card_d  = 4'd0;
`endif
    valid_d = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (DRAW) begin
          if (left_q == 8'd0) begin
            err_d = 1'b1;
          end else begin
            state_d = PICK;
            tries_d = 8'd0;
            busy_d  = 1'b1;
          end
        end
      end
      PICK: begin
        lfsr_d = lfsr_nxt;
        rank_d = lfsr_nxt[3:0];
        if (pick_ok) begin
          state_d = DEAL;
        end else if (tries_q == LAST_TRY) begin
          state_d = SCAN;
          rank_d  = 4'd0;
        end else begin
          tries_d = tries_q + 8'd1;
        end
      end
      // Shoe is non-empty here, so the scan stops at or before rank 12.
      SCAN: begin
        if (cnt_q[rank_q] != 4'd0) begin
          state_d = DEAL;
        end else begin
          rank_d = rank_q + 4'd1;
        end
      end
      DEAL: begin
        cnt_d[rank_q] = cnt_q[rank_q] - 4'd1;
        left_d  = left_q - 8'd1;
        card_d  = rank_value(rank_q);
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (SHUFFLE) begin
      for (int i = 0; i < 13; i++) begin
        cnt_d[i] = RANK_FULL;
      end
      left_d  = SHOE_FULL;
      lfsr_d  = lfsr_q;
      state_d = IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      card_d  = 4'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      for (int i = 0; i < 13; i++) begin
        cnt_q[i] <= RANK_FULL;
      end
      left_q  <= SHOE_FULL;
      lfsr_q  <= (SEED == 16'h0) ? SEED_ZERO : SEED;
      tries_q <= 8'd0;
      rank_q  <= 4'd0;
      card_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      lfsr_q  <= lfsr_d;
      tries_q <= tries_d;
      rank_q  <= rank_d;
      card_q  <= card_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign CARD       = card_q;
  assign CARD_VALID = valid_q;
  assign BUSY       = busy_q;
  assign ERR        = err_q;
  assign CARDS_LEFT = left_q;
  assign EMPTY      = (left_q == 8'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: shoe model predicts every card and its latency.
// Honors DEALER_HOLD_CARD_EN for the idle value of CARD.
module tb_card_dealer;

  localparam int DECKS     = 1;
  localparam int ACE_VALUE = 11;
  localparam int MAX_TRIES = 16;
  localparam int FULL      = 52 * DECKS;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] SEED = 16'h0;
  logic        DRAW = 1'b0;
  logic        SHUFFLE = 1'b0;
  logic [3:0]  CARD;
  logic        CARD_VALID;
  logic        BUSY;
  logic        EMPTY;
  logic        ERR;
  logic [7:0]  CARDS_LEFT;

  int checks = 0;
  int failures = 0;

  int          m_cnt [13];
  int          m_left;
  logic [15:0] m_lfsr;
  logic [3:0]  m_hold;
  bit          m_scanned;
  int          hist [16];

  card_dealer #(
    .DECKS(DECKS),
    .ACE_VALUE(ACE_VALUE),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SEED(SEED),
    .DRAW(DRAW),
    .SHUFFLE(SHUFFLE),
    .CARD(CARD),
    .CARD_VALID(CARD_VALID),
    .BUSY(BUSY),
    .EMPTY(EMPTY),
    .ERR(ERR),
    .CARDS_LEFT(CARDS_LEFT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0);
  endfunction

  function automatic int card_of(input int rank);
    if (rank == 0) return ACE_VALUE;
    if (rank <= 8) return rank + 1;
    return 10;
  endfunction

  task automatic model_fill;
    for (int i = 0; i < 13; i++) m_cnt[i] = 4 * DECKS;
    m_left = FULL;
    m_hold = 4'd0;
  endtask

  // Random picks first, then first non-empty rank; returns cycles to strobe.
  task automatic model_draw(output int rank, output int lat);
    int  tries;
    int  r;
    bit  found;
    tries = 0;
    found = 0;
    rank = 0;
    m_scanned = 0;
    while (!found && tries < MAX_TRIES) begin
      m_lfsr = galois(m_lfsr);
      tries++;
      r = int'(m_lfsr[3:0]);
      if (r <= 12 && m_cnt[r] > 0) begin
        found = 1;
        rank = r;
      end
    end
    if (found) begin
      lat = tries + 1;
    end else begin
      m_scanned = 1;
      while (m_cnt[rank] == 0) rank++;
      lat = MAX_TRIES + rank + 2;
    end
    m_cnt[rank]--;
    m_left--;
  endtask

  task automatic do_reset(input logic [15:0] seed);
    RESET = 1'b1;
    SEED = seed;
    DRAW = 1'b0;
    SHUFFLE = 1'b0;
    tick;
    tick;
    RESET = 1'b0;
    SEED = 16'($urandom);
    m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    model_fill;
  endtask

  task automatic run_draw(output logic [3:0] got);
    int         rank;
    int         lat;
    int         n;
    logic [3:0] exp_card;
    model_draw(rank, lat);
    exp_card = 4'(card_of(rank));
    DRAW = 1'b1;
    tick;
    DRAW = 1'b0;
    n = 0;
    while (CARD_VALID !== 1'b1 && n < MAX_TRIES + 16) begin
      checks++;
      if (BUSY !== 1'b1 || CARD !== m_hold) begin
        failures++;
        $display("FAIL draw_busy busy=%b card=%0d want busy=1 card=%0d",
                 BUSY, CARD, m_hold);
      end
      DRAW = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    DRAW = 1'b0;
    checks++;
    if (n !== lat) begin
      failures++;
      $display("FAIL draw_latency got=%0d want=%0d", n, lat);
    end
    checks++;
    if (CARD_VALID !== 1'b1 || CARD !== exp_card) begin
      failures++;
      $display("FAIL draw_card valid=%b card=%0d want=%0d",
               CARD_VALID, CARD, exp_card);
    end
    checks++;
    if (BUSY !== 1'b0 || CARDS_LEFT !== 8'(m_left)) begin
      failures++;
      $display("FAIL draw_left busy=%b left=%0d want busy=0 left=%0d",
               BUSY, CARDS_LEFT, m_left);
    end
    got = CARD;
`ifdef DEALER_HOLD_CARD_EN
    m_hold = exp_card;
`else
    m_hold = 4'd0;
`endif
  endtask

  task automatic idle_gap;
    int g;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) begin
      tick;
      checks++;
      if (CARD_VALID !== 1'b0 || CARD !== m_hold) begin
        failures++;
        $display("FAIL idle_card valid=%b card=%0d want valid=0 card=%0d",
                 CARD_VALID, CARD, m_hold);
      end
    end
  endtask

  task automatic test_reset;
    do_reset(16'h0);
    checks++;
    if (CARDS_LEFT !== 8'(FULL) || CARD !== 4'd0 || CARD_VALID !== 1'b0 ||
        BUSY !== 1'b0 || ERR !== 1'b0 || EMPTY !== 1'b0) begin
      failures++;
      $display("FAIL reset left=%0d card=%0d v=%b b=%b e=%b em=%b want 52/0/0/0/0/0",
               CARDS_LEFT, CARD, CARD_VALID, BUSY, ERR, EMPTY);
    end
  endtask

  task automatic test_full_deck;
    logic [3:0] c;
    int         want;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    for (int k = 0; k < FULL; k++) begin
      run_draw(c);
      hist[c]++;
      idle_gap;
    end
    for (int v = 0; v < 16; v++) begin
      want = 0;
      if (v == 10) want += 16 * DECKS;
      else if (v >= 2 && v <= 9) want += 4 * DECKS;
      if (v == ACE_VALUE) want += 4 * DECKS;
      checks++;
      if (hist[v] !== want) begin
        failures++;
        $display("FAIL histogram value=%0d got=%0d want=%0d", v, hist[v], want);
      end
    end
    checks++;
    if (EMPTY !== 1'b1 || CARDS_LEFT !== 8'd0) begin
      failures++;
      $display("FAIL deck_empty empty=%b left=%0d want 1/0", EMPTY, CARDS_LEFT);
    end
  endtask

  task automatic test_empty_err;
    for (int k = 0; k < 2; k++) begin
      DRAW = 1'b1;
      tick;
      DRAW = 1'b0;
      checks++;
      if (ERR !== 1'b1 || CARD_VALID !== 1'b0 || BUSY !== 1'b0 ||
          CARDS_LEFT !== 8'd0) begin
        failures++;
        $display("FAIL empty_err err=%b v=%b b=%b left=%0d want 1/0/0/0",
                 ERR, CARD_VALID, BUSY, CARDS_LEFT);
      end
      tick;
      checks++;
      if (ERR !== 1'b0 || CARD_VALID !== 1'b0) begin
        failures++;
        $display("FAIL empty_err_clear err=%b v=%b want 0/0", ERR, CARD_VALID);
      end
    end
  endtask

  task automatic expect_no_strobe(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < MAX_TRIES + 16; i++) begin
      tick;
      if (CARD_VALID !== 1'b0 || BUSY !== 1'b0) seen = 1;
    end
    checks++;
    if (seen || CARDS_LEFT !== 8'(FULL)) begin
      failures++;
      $display("FAIL %s strobe_or_busy=%b left=%0d want 0/%0d",
               name, seen, CARDS_LEFT, FULL);
    end
  endtask

  task automatic test_shuffle;
    logic [3:0] c;
    SHUFFLE = 1'b1;
    tick;
    SHUFFLE = 1'b0;
    model_fill;
    checks++;
    if (CARDS_LEFT !== 8'(FULL) || EMPTY !== 1'b0 || CARD !== 4'd0) begin
      failures++;
      $display("FAIL shuffle_refill left=%0d empty=%b card=%0d want %0d/0/0",
               CARDS_LEFT, EMPTY, CARD, FULL);
    end
    run_draw(c);
    DRAW = 1'b1;
    tick;
    DRAW = 1'b0;
    SHUFFLE = 1'b1;
    tick;
    SHUFFLE = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || CARDS_LEFT !== 8'(FULL) || CARD_VALID !== 1'b0) begin
      failures++;
      $display("FAIL shuffle_abort busy=%b left=%0d v=%b want 0/%0d/0",
               BUSY, CARDS_LEFT, CARD_VALID, FULL);
    end
    expect_no_strobe("shuffle_abort_quiet");
    do_reset(16'($urandom_range(1, 65535)));
    run_draw(c);
    tick;
    DRAW = 1'b1;
    SHUFFLE = 1'b1;
    tick;
    DRAW = 1'b0;
    SHUFFLE = 1'b0;
    model_fill;
    checks++;
    if (BUSY !== 1'b0 || CARDS_LEFT !== 8'(FULL)) begin
      failures++;
      $display("FAIL shuffle_draw_same busy=%b left=%0d want 0/%0d",
               BUSY, CARDS_LEFT, FULL);
    end
    expect_no_strobe("shuffle_draw_quiet");
  endtask

  task automatic test_seed_repeat;
    logic [3:0] seq [20];
    logic [3:0] c;
    do_reset(16'h1234);
    for (int k = 0; k < 20; k++) begin
      run_draw(c);
      seq[k] = c;
    end
    do_reset(16'h1234);
    for (int k = 0; k < 20; k++) begin
      run_draw(c);
      checks++;
      if (c !== seq[k]) begin
        failures++;
        $display("FAIL seed_repeat idx=%0d got=%0d want=%0d", k, c, seq[k]);
      end
    end
    DRAW = 1'b1;
    tick;
    DRAW = 1'b0;
    do_reset(16'h1234);
    checks++;
    if (BUSY !== 1'b0 || CARD_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_draw busy=%b v=%b want 0/0", BUSY, CARD_VALID);
    end
    expect_no_strobe("reset_mid_draw_quiet");
  endtask

  task automatic test_scan;
    logic [3:0] c;
    int         hits;
    hits = 0;
    for (int r = 0; r < 20 && hits == 0; r++) begin
      SHUFFLE = 1'b1;
      tick;
      SHUFFLE = 1'b0;
      model_fill;
      for (int k = 0; k < FULL - 1; k++) run_draw(c);
      run_draw(c);
      if (m_scanned) hits++;
      checks++;
      if (EMPTY !== 1'b1) begin
        failures++;
        $display("FAIL scan_last empty=%b want 1", EMPTY);
      end
    end
    checks++;
    if (hits == 0) begin
      failures++;
      $display("FAIL scan_path_hit got=0 want>=1");
    end
  endtask

  initial begin
    test_reset;
    test_full_deck;
    test_empty_err;
    test_shuffle;
    test_seed_repeat;
    test_scan;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
